trap_sequencer: RTL and testbench
=================================

Name: trap_sequencer

Overview:
Machine-mode trap controller that owns the single access port of the CSRs block. It shares that port between core CSR instructions and its own multi-cycle trap-entry and mret sequences. It prioritises exceptions and interrupts, writes mepc/mcause/mtval/mstatus in order, stalls the core, and issues the redirect PC. It sits between the decode/execute stage and the CSR file.

Parameters:
XLEN, 32, register/datapath width (32 or 64)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous reset, active-high
core_req  in  1  core CSR access request
core_we  in  1  core access is a write
core_addr  in  12  core CSR address
core_wdata  in  XLEN  core write data
core_gnt  out  1  core access accepted this cycle
core_rdata  out  XLEN  read data (csr_dout passthrough)
exc_illegal  in  1  illegal-instruction exception, level
exc_break  in  1  ebreak, level
exc_ecall  in  1  ecall from M-mode, level
exc_tval  in  XLEN  trap value for the current exception
irq_mei, irq_msi, irq_mti  in  1 each  pending external/software/timer interrupt lines
mstatus_mie  in  1  sideband copy of mstatus.MIE
mie_bits  in  3  sideband {MEIE, MSIE, MTIE}
is_mret  in  1  mret executing, level
pc_now  in  XLEN  PC of the faulting/current instruction
csr_w  out  1  CSR file write enable
csr_addr  out  12  CSR file address
csr_din  out  XLEN  CSR file write data
csr_dout  in  XLEN  CSR file read data (asynchronous read)
stall  out  1  hold core pipeline
trap_pc  out  1  redirect strobe, one cycle
pc_trap  out  XLEN  redirect target

Behaviour:
- States: IDLE, RD_MSTATUS, WR_MEPC, WR_MCAUSE, WR_MTVAL, WR_MSTATUS, RD_MTVEC, REDIRECT (trap); RET_RD_MSTATUS, RET_WR_MSTATUS, RET_RD_MEPC, REDIRECT (mret).
- Reset: state IDLE; all registered outputs 0 (stall, trap_pc, pc_trap, csr_w, csr_addr, csr_din); core_gnt 0 while rst is high. Reset mid-sequence aborts the sequence with no rollback of CSR writes already made.
- Events are evaluated only in IDLE.
- Exception priority: illegal (cause 2) > break (3) > ecall (11).
- An interrupt is taken only if no exception is present and mstatus_mie=1. Interrupt priority: MEI (11) > MSI (3) > MTI (7). Each line is gated by its mie_bits bit.
- Any exception beats is_mret in the same cycle. Interrupts beat is_mret.
- On the detection cycle in IDLE:
  - capture pc_now, cause and interrupt flag; capture tval (0 for interrupts and ecall/break).
  - assert stall combinationally; do not grant the core.
- Trap sequence: one state per cycle.
  - RD_MSTATUS latches csr_dout.
  - WR_MEPC writes {pc, bit0=0}.
  - WR_MCAUSE writes {intr, cause} with intr at bit XLEN-1.
  - WR_MTVAL writes tval.
  - WR_MSTATUS writes old mstatus with MPIE(7)<=MIE(3), MIE<=0, MPP(12:11)=11.
  - RD_MTVEC computes the target: base = mtvec & ~3. If mode==1 and the trap is an interrupt, target = base + 4*cause; else target = base.
  - REDIRECT asserts trap_pc=1 with pc_trap=target, then returns to IDLE.
- Trap timing: stall=1 from the detection cycle through REDIRECT inclusive, 8 cycles total.
- mret sequence:
  - RET_RD_MSTATUS latches mstatus.
  - RET_WR_MSTATUS writes MIE<=MPIE, MPIE<=1, MPP=11.
  - RET_RD_MEPC latches mepc.
  - REDIRECT asserts pc_trap=mepc. 5 stalled cycles total.
- Core port:
  - core_gnt = core_req & IDLE & no event & !rst.
  - On grant: csr_addr=core_addr, csr_w=core_we, csr_din=core_wdata. The write lands at the next edge.
  - core_rdata always equals csr_dout.
- In sequencer states, csr_w is 1 only in WR_* states.
- Level inputs still high on return to IDLE are re-evaluated. The core must drop them after trap_pc.

Test Plan:
- mtvec=0x100, mstatus.MIE=1, exc_ecall with pc_now=0x80 → mepc=0x80, mcause=11, mtval=0, mstatus MIE=0 MPIE=1 MPP=11; trap_pc pulse with pc_trap=0x100 on the 8th stalled cycle.
- mtvec=0x201, mie_bits=3'b001, mstatus_mie=1, irq_mti → mcause=0x80000007, pc_trap=0x21C; same with mstatus_mie=0 → no stall, no trap.
- exc_illegal (tval=0xDEAD) together with irq_mei and is_mret → mcause=2, mtval=0xDEAD, no mret.
- mepc=0x1234, mstatus MPIE=1 MIE=0, is_mret → pc_trap=0x1234 after 5 cycles; mstatus MIE=1, MPIE=1.
- core_req write of mscratch=0xA5 during a trap sequence → core_gnt=0 until IDLE; then granted and mscratch reads back 0xA5.
- rst asserted in WR_MCAUSE → next cycle IDLE, stall=0, csr_w=0, no trap_pc.

Source files
------------

// File: rtl/trap_sequencer.sv
// Machine-mode trap controller: arbitrates the single CSR port between core CSR ops
// and multi-cycle trap-entry / mret sequences, then redirects the PC.
module trap_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            core_req,
    input  logic            core_we,
    input  logic [11:0]     core_addr,
    input  logic [XLEN-1:0] core_wdata,
    output logic            core_gnt,
    output logic [XLEN-1:0] core_rdata,
    input  logic            exc_illegal,
    input  logic            exc_break,
    input  logic            exc_ecall,
    input  logic [XLEN-1:0] exc_tval,
    input  logic            irq_mei,
    input  logic            irq_msi,
    input  logic            irq_mti,
    input  logic            mstatus_mie,
    input  logic [2:0]      mie_bits,
    input  logic            is_mret,
    input  logic [XLEN-1:0] pc_now,
    output logic            csr_w,
    output logic [11:0]     csr_addr,
    output logic [XLEN-1:0] csr_din,
    input  logic [XLEN-1:0] csr_dout,
    output logic            stall,
    output logic            trap_pc,
    output logic [XLEN-1:0] pc_trap
);

    localparam logic [11:0] A_MSTATUS = 12'h300;
    localparam logic [11:0] A_MTVEC   = 12'h305;
    localparam logic [11:0] A_MEPC    = 12'h341;
    localparam logic [11:0] A_MCAUSE  = 12'h342;
    localparam logic [11:0] A_MTVAL   = 12'h343;

    typedef enum logic [3:0] {
        IDLE, RD_MSTATUS, WR_MEPC, WR_MCAUSE, WR_MTVAL, WR_MSTATUS, RD_MTVEC,
        REDIRECT, RET_RD_MSTATUS, RET_WR_MSTATUS, RET_RD_MEPC
    } state_t;

    state_t          state;
    logic [XLEN-1:0] cap_pc;
    logic [3:0]      cap_cause;
    logic            cap_intr;
    logic [XLEN-1:0] cap_tval;
    logic [XLEN-1:0] old_mstatus;
    logic            stall_q;
    logic            seq_w;
    logic [11:0]     seq_addr;
    logic [XLEN-1:0] seq_din;

    logic            exc_any;
    logic [2:0]      irq_vec;
    logic            irq_take;
    logic            trap_evt;
    logic            idle_evt;
    logic [3:0]      cause_sel;
    logic [XLEN-1:0] tval_sel;
    logic [XLEN-1:0] mtvec_base;
    logic [XLEN-1:0] vec_target;

    function automatic logic [XLEN-1:0] trap_mstatus(input logic [XLEN-1:0] s);
        logic [XLEN-1:0] r;
        r         = s;
        r[7]      = s[3];
        r[3]      = 1'b0;
        r[12:11]  = 2'b11;
        return r;
    endfunction

    function automatic logic [XLEN-1:0] ret_mstatus(input logic [XLEN-1:0] s);
        logic [XLEN-1:0] r;
        r         = s;
        r[3]      = s[7];
        r[7]      = 1'b1;
        r[12:11]  = 2'b11;
        return r;
    endfunction

    assign exc_any  = exc_illegal | exc_break | exc_ecall;
    assign irq_vec  = {irq_mei, irq_msi, irq_mti} & mie_bits;
    assign irq_take = !exc_any && mstatus_mie && (|irq_vec);
    assign trap_evt = exc_any | irq_take;
    assign idle_evt = (state == IDLE) && (trap_evt || is_mret) && !rst;

    always_comb begin
        cause_sel = 4'd7;
        if (exc_illegal)     cause_sel = 4'd2;
        else if (exc_break)  cause_sel = 4'd3;
        else if (exc_ecall)  cause_sel = 4'd11;
        else if (irq_vec[2]) cause_sel = 4'd11;
        else if (irq_vec[1]) cause_sel = 4'd3;
    end

    assign tval_sel   = exc_illegal ? exc_tval : '0;
    assign mtvec_base = csr_dout & ~XLEN'(3);
    assign vec_target = (csr_dout[1:0] == 2'b01 && cap_intr)
                      ? mtvec_base + {{(XLEN-6){1'b0}}, cap_cause, 2'b00}
                      : mtvec_base;

    // Core owns the CSR port only in an idle cycle with no pending event.
    assign core_gnt   = core_req && (state == IDLE) && !idle_evt && !rst;
    assign core_rdata = csr_dout;
    assign csr_w      = core_gnt ? core_we    : seq_w;
    assign csr_addr   = core_gnt ? core_addr  : seq_addr;
    assign csr_din    = core_gnt ? core_wdata : seq_din;
    assign stall      = stall_q | idle_evt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cap_pc      <= '0;
            cap_cause   <= '0;
            cap_intr    <= 1'b0;
            cap_tval    <= '0;
            old_mstatus <= '0;
            stall_q     <= 1'b0;
            seq_w       <= 1'b0;
            seq_addr    <= '0;
            seq_din     <= '0;
            trap_pc     <= 1'b0;
            pc_trap     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    seq_w    <= 1'b0;
                    seq_addr <= '0;
                    seq_din  <= '0;
                    trap_pc  <= 1'b0;
                    if (trap_evt) begin
                        cap_pc    <= pc_now & ~XLEN'(1);
                        cap_cause <= cause_sel;
                        cap_intr  <= !exc_any;
                        cap_tval  <= tval_sel;
                        seq_addr  <= A_MSTATUS;
                        stall_q   <= 1'b1;
                        state     <= RD_MSTATUS;
                    end else if (is_mret) begin
                        seq_addr  <= A_MSTATUS;
                        stall_q   <= 1'b1;
                        state     <= RET_RD_MSTATUS;
                    end
                end
                RD_MSTATUS: begin
                    old_mstatus <= csr_dout;
                    seq_w       <= 1'b1;
                    seq_addr    <= A_MEPC;
                    seq_din     <= cap_pc;
                    state       <= WR_MEPC;
                end
                WR_MEPC: begin
                    seq_addr <= A_MCAUSE;
                    seq_din  <= {cap_intr, {(XLEN-5){1'b0}}, cap_cause};
                    state    <= WR_MCAUSE;
                end
                WR_MCAUSE: begin
                    seq_addr <= A_MTVAL;
                    seq_din  <= cap_tval;
                    state    <= WR_MTVAL;
                end
                WR_MTVAL: begin
                    seq_addr <= A_MSTATUS;
                    seq_din  <= trap_mstatus(old_mstatus);
                    state    <= WR_MSTATUS;
                end
                WR_MSTATUS: begin
                    seq_w    <= 1'b0;
                    seq_addr <= A_MTVEC;
                    seq_din  <= '0;
                    state    <= RD_MTVEC;
                end
                RD_MTVEC: begin
                    seq_addr <= '0;
                    pc_trap  <= vec_target;
                    trap_pc  <= 1'b1;
                    state    <= REDIRECT;
                end
                REDIRECT: begin
                    trap_pc <= 1'b0;
                    stall_q <= 1'b0;
                    state   <= IDLE;
                end
                RET_RD_MSTATUS: begin
                    seq_w   <= 1'b1;
                    seq_din <= ret_mstatus(csr_dout);
                    state   <= RET_WR_MSTATUS;
                end
                RET_WR_MSTATUS: begin
                    seq_w    <= 1'b0;
                    seq_addr <= A_MEPC;
                    seq_din  <= '0;
                    state    <= RET_RD_MEPC;
                end
                RET_RD_MEPC: begin
                    seq_addr <= '0;
                    pc_trap  <= csr_dout;
                    trap_pc  <= 1'b1;
                    state    <= REDIRECT;
                end
                default: begin
                    stall_q <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed bench for trap_sequencer with a behavioural CSR file and a redirect scoreboard.
module tb_trap_sequencer;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            core_req, core_we;
    logic [11:0]     core_addr;
    logic [XLEN-1:0] core_wdata;
    logic            core_gnt;
    logic [XLEN-1:0] core_rdata;
    logic            exc_illegal, exc_break, exc_ecall;
    logic [XLEN-1:0] exc_tval;
    logic            irq_mei, irq_msi, irq_mti;
    logic            mstatus_mie;
    logic [2:0]      mie_bits;
    logic            is_mret;
    logic [XLEN-1:0] pc_now;
    logic            csr_w;
    logic [11:0]     csr_addr;
    logic [XLEN-1:0] csr_din;
    logic [XLEN-1:0] csr_dout;
    logic            stall, trap_pc;
    logic [XLEN-1:0] pc_trap;

    always #5 clk = ~clk;

    trap_sequencer #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_gnt(core_gnt), .core_rdata(core_rdata),
        .exc_illegal(exc_illegal), .exc_break(exc_break), .exc_ecall(exc_ecall),
        .exc_tval(exc_tval), .irq_mei(irq_mei), .irq_msi(irq_msi), .irq_mti(irq_mti),
        .mstatus_mie(mstatus_mie), .mie_bits(mie_bits), .is_mret(is_mret),
        .pc_now(pc_now), .csr_w(csr_w), .csr_addr(csr_addr), .csr_din(csr_din),
        .csr_dout(csr_dout), .stall(stall), .trap_pc(trap_pc), .pc_trap(pc_trap)
    );

    logic [XLEN-1:0] csrs [0:4095];
    always @(posedge clk) if (csr_w) csrs[csr_addr] <= csr_din;
    assign csr_dout = csrs[csr_addr];

    typedef struct {
        logic [XLEN-1:0] pc;
        int              cycles;
        string           tag;
    } exp_t;
    exp_t sb[$];

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic csr_write(input logic [11:0] a, input logic [XLEN-1:0] d);
        @(negedge clk);
        core_req = 1'b1; core_we = 1'b1; core_addr = a; core_wdata = d;
        @(negedge clk);
        core_req = 1'b0; core_we = 1'b0;
    endtask

    task automatic csr_read(input logic [11:0] a, output logic [XLEN-1:0] d);
        core_req = 1'b1; core_we = 1'b0; core_addr = a;
        #1 d = core_rdata;
        core_req = 1'b0;
        @(negedge clk);
    endtask

    // Called at the negedge on which the event is driven; returns inside the REDIRECT cycle.
    task automatic wait_redirect();
        int   cyc = 0;
        bit   seen = 0;
        bit   gnt_seen = 0;
        exp_t e;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (stall) cyc++;
            if (core_gnt) gnt_seen = 1'b1;
            if (trap_pc) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (sb.size() == 0) begin
            checks++; failures++;
            $error("FAIL sb_underflow observed=0 expected=1");
        end else begin
            e = sb.pop_front();
            if (!seen) begin
                checks++; failures++;
                $error("FAIL %s_timeout observed=0 expected=1", e.tag);
            end else begin
                check({e.tag, "_pc"}, pc_trap, e.pc);
                check({e.tag, "_cycles"}, cyc, e.cycles);
                check({e.tag, "_nogrant"}, gnt_seen, 0);
            end
        end
    endtask

    task automatic quiet_window(input string tag, input int n);
        bit busy = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1 if (stall || trap_pc) busy = 1'b1;
        end
        check(tag, busy, 0);
    endtask

    logic [XLEN-1:0] rd;

    initial begin
        rst = 1'b1;
        core_req = 1'b1; core_we = 1'b0; core_addr = 12'h340; core_wdata = '0;
        exc_illegal = 0; exc_break = 0; exc_ecall = 0; exc_tval = '0;
        irq_mei = 0; irq_msi = 0; irq_mti = 0;
        mstatus_mie = 0; mie_bits = 3'b000; is_mret = 0; pc_now = '0;

        repeat (2) @(negedge clk);
        #1;
        check("rst_core_gnt", core_gnt, 0);
        check("rst_stall", stall, 0);
        check("rst_trap_pc", trap_pc, 0);
        check("rst_pc_trap", pc_trap, 0);
        check("rst_csr_w", csr_w, 0);
        check("rst_csr_addr", csr_addr, 0);
        check("rst_csr_din", csr_din, 0);
        @(negedge clk);
        rst = 1'b0; core_req = 1'b0;

        // ecall trap, direct mode
        csr_write(12'h305, 32'h100);
        csr_write(12'h300, 32'h8);
        mstatus_mie = 1'b1;
        exc_ecall = 1'b1; pc_now = 32'h80;
        sb.push_back('{32'h100, 8, "ecall"});
        wait_redirect();
        exc_ecall = 1'b0;
        @(negedge clk);
        #1 check("ecall_idle_stall", stall, 0);
        check("ecall_idle_trap_pc", trap_pc, 0);
        csr_read(12'h341, rd); check("ecall_mepc", rd, 32'h80);
        csr_read(12'h342, rd); check("ecall_mcause", rd, 32'd11);
        csr_read(12'h343, rd); check("ecall_mtval", rd, 32'h0);
        csr_read(12'h300, rd); check("ecall_mstatus", rd, 32'h1880);

        // vectored timer interrupt
        csr_write(12'h305, 32'h201);
        @(negedge clk);
        mie_bits = 3'b001; mstatus_mie = 1'b1; irq_mti = 1'b1; pc_now = 32'h84;
        sb.push_back('{32'h21C, 8, "irq_mti"});
        wait_redirect();
        irq_mti = 1'b0;
        @(negedge clk);
        csr_read(12'h342, rd); check("mti_mcause", rd, 32'h80000007);
        csr_read(12'h343, rd); check("mti_mtval", rd, 32'h0);

        // same interrupt masked by mstatus.MIE
        mstatus_mie = 1'b0; irq_mti = 1'b1;
        quiet_window("mti_masked_quiet", 10);
        csr_read(12'h342, rd); check("mti_masked_mcause", rd, 32'h80000007);
        irq_mti = 1'b0;

        // illegal beats MEI and mret
        mstatus_mie = 1'b1; mie_bits = 3'b100;
        exc_illegal = 1'b1; exc_tval = 32'hDEAD; irq_mei = 1'b1; is_mret = 1'b1;
        pc_now = 32'h44;
        sb.push_back('{32'h200, 8, "illegal"});
        wait_redirect();
        exc_illegal = 1'b0; irq_mei = 1'b0; is_mret = 1'b0;
        @(negedge clk);
        csr_read(12'h342, rd); check("ill_mcause", rd, 32'd2);
        csr_read(12'h343, rd); check("ill_mtval", rd, 32'hDEAD);
        csr_read(12'h341, rd); check("ill_mepc", rd, 32'h44);

        // mret
        mstatus_mie = 1'b0;
        csr_write(12'h341, 32'h1234);
        csr_write(12'h300, 32'h80);
        is_mret = 1'b1;
        sb.push_back('{32'h1234, 5, "mret"});
        wait_redirect();
        is_mret = 1'b0;
        @(negedge clk);
        csr_read(12'h300, rd); check("mret_mstatus", rd, 32'h1888);

        // core write held off during a trap
        csr_write(12'h305, 32'h100);
        csr_write(12'h340, 32'h0);
        exc_ecall = 1'b1; pc_now = 32'h90;
        core_req = 1'b1; core_we = 1'b1; core_addr = 12'h340; core_wdata = 32'hA5;
        sb.push_back('{32'h100, 8, "ecall_core"});
        wait_redirect();
        exc_ecall = 1'b0;
        @(negedge clk);
        #1 check("core_gnt_after_trap", core_gnt, 1);
        @(negedge clk);
        core_req = 1'b0; core_we = 1'b0;
        csr_read(12'h340, rd); check("mscratch_readback", rd, 32'hA5);

        // reset in WR_MCAUSE
        exc_ecall = 1'b1; pc_now = 32'hC0;
        repeat (3) @(negedge clk);
        #1 check("abort_in_mcause_w", csr_w, 1);
        check("abort_in_mcause_addr", csr_addr, 12'h342);
        rst = 1'b1; exc_ecall = 1'b0;
        core_req = 1'b1; core_we = 1'b0; core_addr = 12'h340;
        @(negedge clk);
        #1 check("abort_stall", stall, 0);
        check("abort_csr_w", csr_w, 0);
        check("abort_trap_pc", trap_pc, 0);
        check("abort_core_gnt", core_gnt, 0);
        rst = 1'b0; core_req = 1'b0;
        quiet_window("abort_quiet", 10);

        check("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

endmodule
